// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and defaults for the LC-3 SRAM access sequencer
// Purpose: FSM state encoding, wait-counter width, data width and MMIO address defaults,
//          plus a saturating increment helper for the wait counter.
// Ports:   none (package)
package lc3_mem_pkg;

   localparam int          DATA_W_DEFAULT    = 16;
   localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;
   localparam int          WAIT_CNT_W        = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_CAPT,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_DONE,
      S_REARM
   } state_t;

   // Counter sticks at all-ones rather than wrapping.
   function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/lc3_sram_ctrl.sv
// rtl/lc3_sram_ctrl.sv - LC-3 memory access sequencer driving asynchronous SRAM strobes
// Purpose: turns level Mem_OE / Mem_WE requests with a MAR address and MDR data into timed,
//          registered SRAM strobes, returns read data and a one-cycle Mem_Ready pulse.
// Optional feature macro: LC3_MMIO_EN (address MMIO_ADDR maps to Switches / HEX_Data).
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Mem_OE, Mem_WE             level read / write requests (write wins)
//   ADDR, Data_from_CPU        word address from MAR, write data from MDR
//   Data_to_CPU, Mem_Ready     last read data, one-cycle completion pulse
//   Busy                       high whenever the sequencer is not idle
//   SRAM_ADDR, SRAM_*_N        registered address and active-low strobes
//   SRAM_DQ_o, SRAM_DQ_oe      write data and its drive enable (tristate built above)
//   SRAM_DQ_i                  read data from the pad
//   Switches, HEX_Data         MMIO read source / write target
module lc3_sram_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int          ADDR_W    = 20,
   parameter int          DATA_W    = DATA_W_DEFAULT,
   parameter int          RD_WAIT   = 2,
   parameter int          WR_WAIT   = 2,
   parameter logic [15:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       ADDR,
   input  logic [DATA_W-1:0] Data_from_CPU,
   output logic [DATA_W-1:0] Data_to_CPU,
   output logic              Mem_Ready,
   output logic              Busy,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic [DATA_W-1:0] SRAM_DQ_o,
   output logic              SRAM_DQ_oe,
   input  logic [DATA_W-1:0] SRAM_DQ_i,
   input  logic [DATA_W-1:0] Switches,
   output logic [DATA_W-1:0] HEX_Data
);

   localparam logic [WAIT_CNT_W-1:0] RD_LAST = WAIT_CNT_W'(RD_WAIT - 1);
   localparam logic [WAIT_CNT_W-1:0] WR_LAST = WAIT_CNT_W'(WR_WAIT - 1);

   state_t                  state, state_nxt;
   logic [WAIT_CNT_W-1:0]   wait_cnt, cnt_nxt;

   logic                    req;
   logic                    accept;
   logic                    mmio_hit;
   logic                    rd_capture;

   logic                    ce_n_nxt, oe_n_nxt, we_n_nxt, bytes_n_nxt, dq_oe_nxt;
   logic                    ready_nxt, busy_nxt;
   logic [DATA_W-1:0]       data_nxt;

   assign req    = Mem_OE | Mem_WE;
   assign accept = (state == S_IDLE) && req;

`ifdef LC3_MMIO_EN
   assign mmio_hit = (ADDR == MMIO_ADDR);
`else
   assign mmio_hit = 1'b0;
   logic unused_mmio;
   assign unused_mmio = ^{Switches, MMIO_ADDR};
`endif

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (mmio_hit)    state_nxt = S_DONE;
               else if (Mem_WE) state_nxt = S_WR_SETUP;
               else             state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT:  if (wait_cnt == RD_LAST) state_nxt = S_RD_CAPT;
         S_RD_CAPT:  state_nxt = S_DONE;
         S_WR_SETUP: state_nxt = S_WR_PULSE;
         S_WR_PULSE: if (wait_cnt == WR_LAST) state_nxt = S_WR_HOLD;
         S_WR_HOLD:  state_nxt = S_DONE;
         // A request still held at completion must drop before the next access.
         S_DONE:     state_nxt = req ? S_REARM : S_IDLE;
         S_REARM:    if (!req) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic: values computed from the upcoming state so every output
   // is a flop that already reflects the state it belongs to.
   // ---------------------------------------------------------------------
   always_comb begin
      ce_n_nxt    = 1'b1;
      oe_n_nxt    = 1'b1;
      we_n_nxt    = 1'b1;
      bytes_n_nxt = 1'b1;
      dq_oe_nxt   = 1'b0;
      case (state_nxt)
         S_RD_WAIT: begin
            ce_n_nxt    = 1'b0;
            oe_n_nxt    = 1'b0;
            bytes_n_nxt = 1'b0;
         end
         S_WR_SETUP, S_WR_HOLD: begin
            ce_n_nxt    = 1'b0;
            bytes_n_nxt = 1'b0;
            dq_oe_nxt   = 1'b1;
         end
         S_WR_PULSE: begin
            ce_n_nxt    = 1'b0;
            we_n_nxt    = 1'b0;
            bytes_n_nxt = 1'b0;
            dq_oe_nxt   = 1'b1;
         end
         default: ;
      endcase

      ready_nxt = (state_nxt == S_DONE);
      busy_nxt  = (state_nxt != S_IDLE);

      // Wait counter runs only while dwelling in a wait state; any entry starts it at zero.
      if (((state == S_RD_WAIT) || (state == S_WR_PULSE)) && (state_nxt == state))
         cnt_nxt = sat_inc(wait_cnt);
      else
         cnt_nxt = '0;

      // Sample the pad on the last OE-low cycle, while the SRAM is still driving it.
      rd_capture = (state == S_RD_WAIT) && (state_nxt == S_RD_CAPT);

      data_nxt = Data_to_CPU;
      if (rd_capture)
         data_nxt = SRAM_DQ_i;
`ifdef LC3_MMIO_EN
      if (accept && mmio_hit && !Mem_WE)
         data_nxt = Switches;
`endif
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         Data_to_CPU <= '0;
         Mem_Ready   <= 1'b0;
         Busy        <= 1'b0;
         SRAM_ADDR   <= '0;
         SRAM_CE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
         SRAM_DQ_o   <= '0;
         SRAM_DQ_oe  <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= cnt_nxt;
         Data_to_CPU <= data_nxt;
         Mem_Ready   <= ready_nxt;
         Busy        <= busy_nxt;
         SRAM_CE_N   <= ce_n_nxt;
         SRAM_OE_N   <= oe_n_nxt;
         SRAM_WE_N   <= we_n_nxt;
         SRAM_UB_N   <= bytes_n_nxt;
         SRAM_LB_N   <= bytes_n_nxt;
         SRAM_DQ_oe  <= dq_oe_nxt;
         if (accept) begin
            SRAM_ADDR <= ADDR_W'(ADDR);
            SRAM_DQ_o <= Data_from_CPU;
         end
      end
   end

`ifdef LC3_MMIO_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         HEX_Data <= '0;
      else if (accept && mmio_hit && Mem_WE)
         HEX_Data <= Data_from_CPU;
   end
`else
   assign HEX_Data = '0;
`endif

endmodule

// File: tb/tb_lc3_sram_ctrl.sv
// tb/tb_lc3_sram_ctrl.sv - scoreboard bench for lc3_sram_ctrl
// Purpose: directed accesses against a small SRAM model; expected read data and Mem_Ready
//          cycle are queued at issue and checked by a monitor whenever Mem_Ready fires.
// Ports:   none (top-level bench)
module tb_lc3_sram_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Mem_OE = 1'b0;
   logic        Mem_WE = 1'b0;
   logic [15:0] ADDR = '0;
   logic [15:0] Data_from_CPU = '0;
   logic [15:0] Data_to_CPU;
   logic        Mem_Ready;
   logic        Busy;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
   logic [15:0] SRAM_DQ_o;
   logic        SRAM_DQ_oe;
   logic [15:0] SRAM_DQ_i;
   logic [15:0] Switches = 16'h00A5;
   logic [15:0] HEX_Data;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   logic [15:0] mem [0:255];

   lc3_sram_ctrl #(
      .ADDR_W(20), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2), .MMIO_ADDR(16'hFFFF)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
      .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
      .Busy(Busy), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_DQ_o(SRAM_DQ_o), .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_DQ_i(SRAM_DQ_i),
      .Switches(Switches), .HEX_Data(HEX_Data)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc = cyc + 1;

   // Asynchronous SRAM: drives data only while selected with OE low; writes while WE low.
   assign SRAM_DQ_i = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'hDEAD;
   always @(negedge Clk)
      if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe)
         mem[SRAM_ADDR[7:0]] = SRAM_DQ_o;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every Mem_Ready pulse must match the oldest queued expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset && Mem_Ready) begin
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_ready: got Mem_Ready at cycle %0d expected no pulse", cyc);
         end else begin
            e = sb_q.pop_front();
            check("ready_data", Data_to_CPU, e.data);
            check("ready_cycle", cyc, e.cyc);
         end
      end
   end

   // Called just after a rising edge; that cycle is cycle 0 of the access.
   // Strobes are recorded per cycle (bit k = cycle k, active-high sense).
   task automatic do_access(input string name, input logic we, input logic oe,
                            input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                            input logic [15:0] exp_data, input int lat,
                            input logic [11:0] e_oe, input logic [11:0] e_we,
                            input logic [11:0] e_ce, input logic [11:0] e_dqoe,
                            input logic [11:0] e_rdy, input logic [11:0] e_busy);
      logic [11:0] m_oe, m_we, m_ce, m_dqoe, m_rdy, m_busy;
      sb_q.push_back('{exp_data, cyc + lat});
      Mem_WE = we; Mem_OE = oe; ADDR = addr; Data_from_CPU = wdata;
      for (int k = 0; k < 12; k++) begin
         @(negedge Clk);
         m_oe[k]   = ~SRAM_OE_N;
         m_we[k]   = ~SRAM_WE_N;
         m_ce[k]   = ~SRAM_CE_N;
         m_dqoe[k] = SRAM_DQ_oe;
         m_rdy[k]  = Mem_Ready;
         m_busy[k] = Busy;
         @(posedge Clk); #1;
         if (k + 1 >= hold) begin
            Mem_WE = 1'b0;
            Mem_OE = 1'b0;
         end
      end
      check({name, "_oe_n"},  32'(m_oe),   32'(e_oe));
      check({name, "_we_n"},  32'(m_we),   32'(e_we));
      check({name, "_ce_n"},  32'(m_ce),   32'(e_ce));
      check({name, "_dq_oe"}, 32'(m_dqoe), 32'(e_dqoe));
      check({name, "_ready"}, 32'(m_rdy),  32'(e_rdy));
      check({name, "_busy"},  32'(m_busy), 32'(e_busy));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected finish before 100000 time units");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      mem[3] = 16'h1234;

      // Reset state
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      check("rst_data",  Data_to_CPU, 16'h0000);
      check("rst_ready", Mem_Ready, 1'b0);
      check("rst_busy",  Busy, 1'b0);
      check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
      check("rst_dq_oe", SRAM_DQ_oe, 1'b0);
      check("rst_addr",  SRAM_ADDR, 20'h0);
      check("rst_hex",   HEX_Data, 16'h0000);

      // Reset held two cycles while in WR_PULSE
      @(posedge Clk); #1;
      Mem_WE = 1'b1; ADDR = 16'h0020; Data_from_CPU = 16'h5555;
      @(posedge Clk); #1;
      Mem_WE = 1'b0;
      @(posedge Clk); #1;
      check("midwr_we_low", SRAM_WE_N, 1'b0);
      Reset = 1'b1;
      @(posedge Clk); #1;
      check("midwr_rst_we_n",  SRAM_WE_N, 1'b1);
      check("midwr_rst_ce_n",  SRAM_CE_N, 1'b1);
      check("midwr_rst_dq_oe", SRAM_DQ_oe, 1'b0);
      check("midwr_rst_busy",  Busy, 1'b0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      check("midwr_after_busy", Busy, 1'b0);

      // Read 0x0003: OE low cycles 1-2, ready cycle 4
      do_access("rd3", 1'b0, 1'b1, 16'h0003, 16'h0000, 1, 16'h1234, 4,
                12'h006, 12'h000, 12'h006, 12'h000, 12'h010, 12'h01E);
      // Write 0x0010 <= BEEF: WE low cycles 2-3, DQ_oe 1-4, ready cycle 5
      do_access("wr10", 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1, 16'h1234, 5,
                12'h000, 12'h00C, 12'h01E, 12'h01E, 12'h020, 12'h03E);
      do_access("rd10", 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'hBEEF, 4,
                12'h006, 12'h000, 12'h006, 12'h000, 12'h010, 12'h01E);
      // Held level: one read, REARM until the request drops
      do_access("hold8", 1'b0, 1'b1, 16'h0003, 16'h0000, 8, 16'h1234, 4,
                12'h006, 12'h000, 12'h006, 12'h000, 12'h010, 12'h1FE);
      do_access("rearm_rd", 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'hBEEF, 4,
                12'h006, 12'h000, 12'h006, 12'h000, 12'h010, 12'h01E);
      // Both requests: write wins, no OE pulse
      do_access("both", 1'b1, 1'b1, 16'h0011, 16'h0F0F, 1, 16'hBEEF, 5,
                12'h000, 12'h00C, 12'h01E, 12'h01E, 12'h020, 12'h03E);
      do_access("rd11", 1'b0, 1'b1, 16'h0011, 16'h0000, 1, 16'h0F0F, 4,
                12'h006, 12'h000, 12'h006, 12'h000, 12'h010, 12'h01E);

`ifdef LC3_MMIO_EN
      do_access("mmio_rd", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1, 16'h00A5, 1,
                12'h000, 12'h000, 12'h000, 12'h000, 12'h002, 12'h002);
      do_access("mmio_wr", 1'b1, 1'b0, 16'hFFFF, 16'h0042, 1, 16'h00A5, 1,
                12'h000, 12'h000, 12'h000, 12'h000, 12'h002, 12'h002);
      check("mmio_hex", HEX_Data, 16'h0042);
`else
      check("hex_const", HEX_Data, 16'h0000);
`endif

      repeat (2) @(posedge Clk);
      check("sb_drained", sb_q.size(), 0);
      check("end_busy", Busy, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
